instr_fetch: RTL and testbench

Instruction fetch stage of the 32-bit RISC-V core, sitting directly upstream of `immediategeneration` and the decoder. It owns the program counter and issues one word fetch at a time to instruction memory over a request/response handshake. It holds each returned word, with its PC, until decode accepts it. On acceptance it forms the next PC from the decoded `pc_src` and the extended immediate, or from the ALU result for `jalr`.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/instr_fetch_pc_next.sv | 28 ++
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: pc_src encodings,
// fetch FSM states, instruction length and reset PC.
package riscv_pkg;

   localparam int          ILEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JALR   = 2'b10;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_FAULT
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next-PC mux/adder with misalignment flag.
// in: instr_pc, pc_src, extimm, alu_result; out: next_pc, misaligned
module pc_next
   import riscv_pkg::*;
#(
   parameter int Width = 32
) (
   input  logic [Width-1:0] instr_pc,
   input  logic [1:0]       pc_src,
   input  logic [Width-1:0] extimm,
   input  logic [Width-1:0] alu_result,
   output logic [Width-1:0] next_pc,
   output logic             misaligned
);

   always_comb begin
      next_pc = instr_pc + Width'(4);
      unique case (pc_src)
         PC_BRANCH: next_pc = instr_pc + extimm;
         PC_JALR:   next_pc = alu_result & ~Width'(1);
         default:   next_pc = instr_pc + Width'(4);
      endcase
   end

   // bit 0 can only be set by a malformed branch offset
   assign misaligned = next_pc[1] | next_pc[0];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, one outstanding imem read, holds word for decode.
// imem_* request/response, instr* to decode, pc_src/extimm/alu_result in, fault/retire out
module instr_fetch
   import riscv_pkg::*;
#(
   parameter int               Width   = 32,
   parameter logic [Width-1:0] ResetPc = Width'(RESET_PC)
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req,
   output logic [Width-1:0] imem_addr,
   input  logic             imem_ready,
   input  logic             imem_rvalid,
   input  logic [ILEN-1:0]  imem_rdata,
   output logic [ILEN-1:0]  instr,
   output logic [Width-1:0] instr_pc,
   output logic             instr_valid,
   input  logic             instr_ready,
   input  logic [1:0]       pc_src,
   input  logic [Width-1:0] extimm,
   input  logic [Width-1:0] alu_result,
   output logic             fetch_fault,
   output logic [Width-1:0] fault_pc,
   output logic [31:0]      retire_count
);

   fetch_state_t     state_q, state_d;
   logic [Width-1:0] pc_q, pc_d;
   logic [ILEN-1:0]  instr_q, instr_d;
   logic [Width-1:0] instr_pc_q, instr_pc_d;
   logic             fault_q, fault_d;
   logic [Width-1:0] fault_pc_q, fault_pc_d;
   logic [31:0]      retire_q, retire_d;

   logic [Width-1:0] next_pc;
   logic             misaligned;

   pc_next #(
      .Width (Width)
   ) u_pc_next (
      .instr_pc   (instr_pc_q),
      .pc_src     (pc_src),
      .extimm     (extimm),
      .alu_result (alu_result),
      .next_pc    (next_pc),
      .misaligned (misaligned)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;
      retire_d   = retire_q;
      unique case (state_q)
         S_REQ: begin
            if (imem_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               instr_d    = imem_rdata;
               instr_pc_d = pc_q;
               state_d    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (instr_ready) begin
               retire_d = retire_q + 32'd1;
               if (misaligned) begin
                  fault_d    = 1'b1;
                  fault_pc_d = next_pc;
                  state_d    = S_FAULT;
               end else begin
                  pc_d    = next_pc;
                  state_d = S_REQ;
               end
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: state_d = S_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_REQ;
         pc_q       <= ResetPc;
         instr_q    <= '0;
         instr_pc_q <= '0;
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
         retire_q   <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
         retire_q   <= retire_d;
      end
   end

   assign imem_req     = (state_q == S_REQ);
   assign imem_addr    = pc_q;
   assign instr_valid  = (state_q == S_HOLD);
   assign instr        = instr_q;
   assign instr_pc     = instr_pc_q;
   assign fetch_fault  = fault_q;
   assign fault_pc     = fault_pc_q;
   assign retire_count = retire_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch.
// Driver models imem and decode; monitor checks outputs against a PC model.
module tb_instr_fetch;

   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [1:0]  pc_src;
   logic [31:0] extimm;
   logic [31:0] alu_result;
   logic        fetch_fault;
   logic [31:0] fault_pc;
   logic [31:0] retire_count;

   instr_fetch #(
      .Width   (32),
      .ResetPc (RPC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .instr        (instr),
      .instr_pc     (instr_pc),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .pc_src       (pc_src),
      .extimm       (extimm),
      .alu_result   (alu_result),
      .fetch_fault  (fetch_fault),
      .fault_pc     (fault_pc),
      .retire_count (retire_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      int unsigned ret;
   } item_t;

   typedef struct {
      logic [1:0]  src;
      logic [31:0] ext;
      logic [31:0] alu;
   } dec_t;

   item_t       inst_q[$];
   logic [31:0] addr_q[$];
   dec_t        dir_q[$];

   int          checks;
   int          errors;

   logic [31:0] m_pc;
   int unsigned m_ret;
   logic [31:0] f_pc;
   int unsigned f_ret;
   int          f_cnt;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0000_0093;
      return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act,
                               input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endfunction

   function automatic void flag(input string nm);
      checks++;
      errors++;
      $display("FAIL %s", nm);
   endfunction

   // memory + decode driver, and the reference PC model
   initial begin
      int          pend;
      int          pdly;
      int          hold;
      int          stale;
      int          s;
      logic [31:0] paddr;
      logic [31:0] nxt;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      instr_ready = 1'b0;
      pc_src      = 2'b00;
      extimm      = '0;
      alu_result  = '0;
      pend  = 0;
      pdly  = 0;
      hold  = 0;
      stale = 0;
      paddr = '0;
      f_cnt = 0;
      f_pc  = '0;
      f_ret = 0;
      m_pc  = RPC;
      m_ret = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_pc  = RPC;
            m_ret = 0;
            addr_q.delete();
            inst_q.delete();
            addr_q.push_back(RPC);
            inst_q.push_back('{RPC, mem_word(RPC), 0});
            if (pend != 0) stale = 1;
            pend = 0;
            hold = 6;
         end else begin
            if (imem_req && imem_ready) begin
               pend  = 1;
               paddr = imem_addr;
               pdly  = $urandom_range(0, 2);
            end
            if (instr_valid && instr_ready) begin
               m_ret++;
               case (pc_src)
                  2'b01:   nxt = m_pc + extimm;
                  2'b10:   nxt = alu_result & 32'hFFFF_FFFE;
                  default: nxt = m_pc + 32'd4;
               endcase
               if (dir_q.size() > 0) void'(dir_q.pop_front());
               if (nxt[1:0] != 2'b00) begin
                  f_pc  = nxt;
                  f_ret = m_ret;
                  f_cnt++;
               end else begin
                  m_pc = nxt;
                  addr_q.push_back(nxt);
                  inst_q.push_back('{nxt, mem_word(nxt), m_ret});
               end
            end
         end
         @(posedge clk);
         #1;
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         if (hold > 0) begin
            imem_ready = 1'b0;
            hold--;
         end else begin
            imem_ready = ($urandom_range(0, 9) < 7);
         end
         if (!rst_n) imem_ready = 1'b0;
         if (stale != 0 && rst_n && hold < 4) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            stale = 0;
         end else if (pend != 0) begin
            if (pdly == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(paddr);
               pend = 0;
            end else begin
               pdly--;
            end
         end else if ($urandom_range(0, 7) == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
         end
         instr_ready = ($urandom_range(0, 9) < 6);
         if (dir_q.size() > 0) begin
            pc_src     = dir_q[0].src;
            extimm     = dir_q[0].ext;
            alu_result = dir_q[0].alu;
         end else begin
            s = $urandom_range(0, 19);
            if (s < 10)      pc_src = 2'b00;
            else if (s < 15) pc_src = 2'b01;
            else if (s < 19) pc_src = 2'b10;
            else             pc_src = 2'b11;
            s = int'($urandom_range(0, 2047)) - 1024;
            extimm = 32'(s * 4);
            if ($urandom_range(0, 15) == 0) extimm[1] = 1'b1;
            alu_result = $urandom;
            alu_result[1] = ($urandom_range(0, 9) == 0);
         end
      end
   end

   // monitor: request addresses and presented instructions
   initial begin
      logic  pv;
      item_t cur;
      pv  = 1'b0;
      cur = '{32'h0, 32'h0, 0};
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pv = 1'b0;
         end else begin
            if (imem_req) begin
               if (addr_q.size() == 0) begin
                  flag("extra_req");
               end else begin
                  chk("imem_addr", imem_addr, addr_q[0]);
                  if (imem_ready) void'(addr_q.pop_front());
               end
            end
            if (instr_valid) begin
               if (!pv) begin
                  if (inst_q.size() == 0) flag("unexpected_valid");
                  else cur = inst_q.pop_front();
               end
               chk("instr", instr, cur.ins);
               chk("instr_pc", instr_pc, cur.pc);
               chk("retire_count", retire_count, 32'(cur.ret));
            end
            pv = instr_valid;
         end
      end
   end

   // call at a negedge: async reset, check reset values, release
   task automatic do_reset();
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_imem_req", 32'(imem_req), 32'd1);
      chk("rst_imem_addr", imem_addr, RPC);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
      chk("rst_fault_pc", fault_pc, 32'h0);
      chk("rst_retire_count", retire_count, 32'h0);
      #2 rst_n = 1'b1;
   endtask

   task automatic wait_fault(input int budget, input bit must, output bit got);
      int c0;
      int n;
      c0  = f_cnt;
      n   = 0;
      got = 1'b0;
      while (f_cnt == c0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (f_cnt == c0) begin
         if (must) flag("fault_timeout");
      end else begin
         got = 1'b1;
         @(negedge clk);
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            chk("fetch_fault", 32'(fetch_fault), 32'd1);
            chk("fault_pc", fault_pc, f_pc);
            chk("fault_imem_req", 32'(imem_req), 32'd0);
            chk("fault_instr_valid", 32'(instr_valid), 32'd0);
            chk("fault_retire", retire_count, 32'(f_ret));
            @(negedge clk);
         end
      end
   endtask

   initial begin
      bit got;
      int n;
      rst_n  = 1'b0;
      checks = 0;
      errors = 0;
      dir_q.push_back('{2'b00, 32'h0, 32'h0});
      dir_q.push_back('{2'b10, 32'h0, 32'h0000_0101});
      dir_q.push_back('{2'b01, 32'hFFFF_FFF8, 32'h0});
      dir_q.push_back('{2'b10, 32'h0, 32'h0000_2005});
      dir_q.push_back('{2'b10, 32'h0, 32'hFFFF_FFFD});
      dir_q.push_back('{2'b00, 32'h0, 32'h0});
      dir_q.push_back('{2'b11, 32'h0, 32'h0});
      dir_q.push_back('{2'b10, 32'h0, 32'h0000_0041});
      dir_q.push_back('{2'b01, 32'h0000_0006, 32'h0});
      @(negedge clk);
      do_reset();
      wait_fault(3000, 1'b1, got);
      for (int ep = 0; ep < 12; ep++) begin
         @(negedge clk);
         do_reset();
         wait_fault(300, 1'b0, got);
         if (!got) begin
            n = 0;
            while (!(!imem_req && !instr_valid && !fetch_fault) && n < 50) begin
               @(negedge clk);
               n++;
            end
         end
      end
      @(negedge clk);
      do_reset();
      repeat (60) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog");
      $fatal(1, "timeout");
   end

endmodule
